// File: rtl/transpose_scheduler.sv
// Round-robin arbiter sharing one matrix_transpose unit among R requesters.
// Captures the winner's matrix, pulses start, waits (with watchdog) for done, then acks.
module transpose_scheduler #(
  parameter int R       = 4,
  parameter int N       = 3,
  parameter int D       = 3,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic        [R-1:0]                          req,
  input  logic signed [R-1:0][N-1:0][D-1:0][WIDTH-1:0] in_mat,
  output logic                                         tp_start,
  output logic signed [N-1:0][D-1:0][WIDTH-1:0]        tp_in,
  input  logic                                         tp_done,
  output logic        [R-1:0]                          grant,
  output logic        [$clog2(R)-1:0]                  grant_id,
  output logic        [R-1:0]                          ack,
  output logic                                         err,
  output logic                                         busy
);

  localparam int IDW = $clog2(R);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [IDW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic                                 tp_start_q, tp_start_d;
  logic signed [N-1:0][D-1:0][WIDTH-1:0] tp_in_q, tp_in_d;
  logic [R-1:0]                         grant_q, grant_d;
  logic [IDW-1:0]                       grant_id_q, grant_id_d;
  logic [R-1:0]                         ack_q, ack_d;
  logic                                 err_q, err_d;
  logic                                 busy_q, busy_d;

  logic                                 found;
  logic [IDW-1:0]                       win_idx;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < R; k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= R) j = j - R;
      if (!found && req[IDW'(j)]) begin
        found   = 1'b1;
        win_idx = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    tp_start_d = 1'b0;
    tp_in_d    = tp_in_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_START;
          grant_d    = R'(1) << win_idx;
          grant_id_d = win_idx;
          tp_in_d    = in_mat[win_idx];
          rr_ptr_d   = (win_idx == IDW'(R-1)) ? '0 : win_idx + 1'b1;
          tp_start_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (tp_done) begin
          state_d = S_ACK;
          ack_d   = grant_q;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          // Watchdog expired: release the owner anyway, flagged as an error.
          state_d = S_ACK;
          ack_d   = grant_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      tp_start_q <= 1'b0;
      tp_in_q    <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      tp_start_q <= tp_start_d;
      tp_in_q    <= tp_in_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign tp_start = tp_start_q;
  assign tp_in    = tp_in_q;
  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_transpose_scheduler.sv
// Scoreboard bench for transpose_scheduler with a behavioural transpose unit attached.
module tb_transpose_scheduler;

  localparam int R  = 4;
  localparam int N  = 3;
  localparam int D  = 3;
  localparam int W  = 8;
  localparam int TO = 15;

  typedef logic signed [N-1:0][D-1:0][W-1:0] mat_t;

  typedef struct {
    int          cyc;
    logic [R-1:0] ack;
    logic [1:0]  id;
    logic        err;
    bit          chk_out;
    mat_t        out;
    bit          chk_in;
    mat_t        tpin;
  } sb_item_t;

  logic                                     clk = 1'b0;
  logic                                     rst_n;
  logic [R-1:0]                             req;
  logic signed [R-1:0][N-1:0][D-1:0][W-1:0] in_mat;
  logic                                     tp_start;
  mat_t                                     tp_in;
  logic                                     tp_done;
  logic [R-1:0]                             grant;
  logic [1:0]                               grant_id;
  logic [R-1:0]                             ack;
  logic                                     err;
  logic                                     busy;

  mat_t     tp_out;
  logic     stuck;
  int       cyc = 0;
  int       acks_seen = 0;
  int       total = 0;
  int       bad = 0;
  sb_item_t sb[$];

  transpose_scheduler #(.R(R), .N(N), .D(D), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n), .req(req), .in_mat(in_mat),
    .tp_start(tp_start), .tp_in(tp_in), .tp_done(tp_done),
    .grant(grant), .grant_id(grant_id), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transpose unit: result and done registered on start; done held 0 when stuck.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_done <= 1'b0;
      tp_out  <= '0;
    end else begin
      tp_done <= tp_start && !stuck;
      if (tp_start)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < D; c++)
            tp_out[c][r] <= tp_in[r][c];
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic mat_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    mat_t m;
    m[0][0] = W'(a0); m[0][1] = W'(a1); m[0][2] = W'(a2);
    m[1][0] = W'(a3); m[1][1] = W'(a4); m[1][2] = W'(a5);
    m[2][0] = W'(a6); m[2][1] = W'(a7); m[2][2] = W'(a8);
    return m;
  endfunction

  task automatic push(input int c, input logic [R-1:0] a, input logic [1:0] id, input logic e,
                      input bit co, input mat_t o, input bit ci, input mat_t ti);
    sb_item_t it;
    it.cyc = c; it.ack = a; it.id = id; it.err = e;
    it.chk_out = co; it.out = o; it.chk_in = ci; it.tpin = ti;
    sb.push_back(it);
  endtask

  // Monitor: every ack the DUT presents is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err && ack == '0)
        check_output("err_without_ack", {127'd0, err}, 128'd0);
      if (ack != '0) begin
        if (sb.size() == 0) begin
          check_output("unexpected_ack", {124'd0, ack}, 128'd0);
        end else begin
          sb_item_t e;
          e = sb.pop_front();
          check_output("ack", {124'd0, ack}, {124'd0, e.ack});
          check_output("grant_at_ack", {124'd0, grant}, {124'd0, e.ack});
          check_output("grant_id", {126'd0, grant_id}, {126'd0, e.id});
          check_output("err", {127'd0, err}, {127'd0, e.err});
          check_output("ack_cycle", 128'(e.cyc), 128'(cyc));
          if (e.chk_out) check_output("tp_out", {56'd0, tp_out}, {56'd0, e.out});
          if (e.chk_in)  check_output("tp_in", {56'd0, tp_in}, {56'd0, e.tpin});
        end
        acks_seen++;
      end
    end
  end

  task automatic wait_acks(input int n, input int budget);
    int target;
    target = acks_seen + n;
    for (int i = 0; i < budget && acks_seen < target; i++) begin
      @(negedge clk); #2;
    end
    if (acks_seen < target) check_output("ack_timeout", 128'(acks_seen), 128'(target));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_tp_start"}, {127'd0, tp_start}, 128'd0);
    check_output({tag, "_tp_in"}, {56'd0, tp_in}, 128'd0);
    check_output({tag, "_grant"}, {124'd0, grant}, 128'd0);
    check_output({tag, "_grant_id"}, {126'd0, grant_id}, 128'd0);
    check_output({tag, "_ack"}, {124'd0, ack}, 128'd0);
    check_output({tag, "_err"}, {127'd0, err}, 128'd0);
    check_output({tag, "_busy"}, {127'd0, busy}, 128'd0);
  endtask

  task automatic apply_stimulus();
    int   c;
    mat_t a;
    mat_t z;
    z = '0;

    rst_n = 1'b0; req = '0; in_mat = '0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    $display("[TB] single request");
    in_mat[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
    req = 4'b0001;
    c = cyc;
    push(c + 3, 4'b0001, 2'd0, 1'b0, 1, mk(1, 4, 7, 2, 5, 8, 3, 6, 9), 1, mk(1, 2, 3, 4, 5, 6, 7, 8, 9));
    @(negedge clk); #2;
    check_output("start_pulse", {127'd0, tp_start}, 128'd1);
    check_output("busy_start", {127'd0, busy}, 128'd1);
    check_output("grant_start", {124'd0, grant}, 128'd1);
    @(negedge clk); #2;
    check_output("start_drop", {127'd0, tp_start}, 128'd0);
    wait_acks(1, 20);
    req = '0;

    $display("[TB] all four requesters");
    apply_reset();
    in_mat[1] = mk(11, 12, 13, 14, 15, 16, 17, 18, 19);
    in_mat[2] = mk(21, 22, 23, 24, 25, 26, 27, 28, 29);
    in_mat[3] = mk(31, 32, 33, 34, 35, 36, 37, 38, 39);
    req = 4'b1111;
    c = cyc;
    push(c + 3,  4'b0001, 2'd0, 1'b0, 0, z, 1, mk(1, 2, 3, 4, 5, 6, 7, 8, 9));
    push(c + 7,  4'b0010, 2'd1, 1'b0, 0, z, 1, mk(11, 12, 13, 14, 15, 16, 17, 18, 19));
    push(c + 11, 4'b0100, 2'd2, 1'b0, 0, z, 1, mk(21, 22, 23, 24, 25, 26, 27, 28, 29));
    push(c + 15, 4'b1000, 2'd3, 1'b0, 1, mk(31, 34, 37, 32, 35, 38, 33, 36, 39), 0, z);
    push(c + 19, 4'b0001, 2'd0, 1'b0, 0, z, 0, z);
    wait_acks(5, 60);
    req = '0;

    $display("[TB] fairness 1001");
    apply_reset();
    req = 4'b1001;
    c = cyc;
    push(c + 3,  4'b0001, 2'd0, 1'b0, 0, z, 0, z);
    push(c + 7,  4'b1000, 2'd3, 1'b0, 0, z, 0, z);
    push(c + 11, 4'b0001, 2'd0, 1'b0, 0, z, 0, z);
    push(c + 15, 4'b1000, 2'd3, 1'b0, 0, z, 0, z);
    wait_acks(4, 60);
    req = '0;

    $display("[TB] stuck unit");
    apply_reset();
    stuck = 1'b1;
    req = 4'b0100;
    c = cyc;
    push(c + 17, 4'b0100, 2'd2, 1'b1, 0, z, 0, z);
    wait_acks(1, 40);
    req = '0;
    @(negedge clk); #2;
    check_output("busy_after_timeout", {127'd0, busy}, 128'd0);
    check_output("grant_after_timeout", {124'd0, grant}, 128'd0);
    stuck = 1'b0;

    $display("[TB] input isolation");
    apply_reset();
    a = mk(10, -20, 30, -40, 50, -60, 70, -80, 90);
    in_mat[1] = a;
    req = 4'b0010;
    c = cyc;
    push(c + 3, 4'b0010, 2'd1, 1'b0, 1, mk(10, -40, 70, -20, 50, -80, 30, -60, 90), 1, a);
    @(negedge clk); #2;
    check_output("grant_iso", {124'd0, grant}, 128'd2);
    @(negedge clk); #2;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < D; k++)
        in_mat[1][r][k] = 8'sh80;
    wait_acks(1, 20);
    req = '0;

    $display("[TB] reset during wait");
    apply_reset();
    stuck = 1'b1;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk); #2;
    stuck = 1'b0;
    rst_n = 1'b1;
    req = 4'b0011;
    c = cyc;
    push(c + 3, 4'b0001, 2'd0, 1'b0, 0, z, 0, z);
    push(c + 7, 4'b0010, 2'd1, 1'b0, 0, z, 0, z);
    wait_acks(2, 40);
    req = '0;

    repeat (3) @(negedge clk);
    #2;
    check_output("sb_leftover", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transpose_scheduler.md
# transpose_scheduler

Round-robin scheduler that shares one `matrix_transpose` unit among R requesters, such as the attention heads needing K^T. It captures the winning requester's matrix and issues the one-cycle `start` to the transpose unit. It then waits for the unit's `done` and returns a one-cycle acknowledge to the winner. A watchdog bounds the wait and reports a stuck unit.

## Interface
- R, 4: number of requesters (2..8)
- N, 3: matrix rows at transpose input
- D, 3: matrix columns at transpose input
- WIDTH, 8: signed element width
- TIMEOUT, 15: max cycles in WAIT without `tp_done` (>=2)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  R  per-requester request level; requester holds it until its `ack`
- in_mat  in  R x N x D x WIDTH signed  per-requester source matrix
- tp_start  out  1  start pulse to transpose unit
- tp_in  out  N x D x WIDTH signed  registered matrix driven to transpose unit
- tp_done  in  1  done pulse from transpose unit
- grant  out  R  one-hot owner, valid START through ACK
- grant_id  out  $clog2(R)  binary index of owner
- ack  out  R  one-cycle completion pulse to owner
- err  out  1  one-cycle pulse with `ack` when the watchdog expired
- busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: all outputs low.
  - START: `tp_start`=1.
  - WAIT: watchdog counting.
  - ACK: `ack[grant_id]`=1.
- IDLE, any `req` bit set:
  - Pick the first set bit at or after `rr_ptr`, searching upward with wrap.
  - On the same edge, register `grant` and `grant_id`, copy `in_mat[winner]` into `tp_in`, set `rr_ptr` = winner+1 mod R, and go to START.
- START: always exactly one cycle, then go to WAIT and clear the watchdog counter to 0.
- WAIT:
  - `tp_done`=1: go to ACK, `err` stays 0.
  - Otherwise increment the counter. At count == TIMEOUT-1 with no `tp_done`, go to ACK with `err` flagged.
- ACK:
  - One cycle, then IDLE.
  - `grant` and `grant_id` clear on the ACK->IDLE edge.
  - The result sits in the transpose unit's `Out`, which holds until its next `start`. The owner samples it during the `ack` cycle.
- `tp_in` holds its value from capture until the next capture; it is not cleared in IDLE.
- `req` deassertion after grant is ignored; the transaction completes and still pulses `ack`.
- `req` of the current owner still high in IDLE after its `ack` is treated as a new request, subject to round-robin.
- `tp_done` seen in IDLE, START or ACK is ignored.
- Reset value of every output: `tp_start`=0, `tp_in`=all 0, `grant`=0, `grant_id`=0, `ack`=0, `err`=0, `busy`=0. Reset also sets `rr_ptr`=0, watchdog counter=0, state IDLE.
- Reset assertion mid-transaction: immediate return to IDLE with reset values. No `ack` is issued, and the requester re-requests.

## Timing
- Request first sampled at edge E0 with `req` high in IDLE:
  - START is cycle E0..E1, with `tp_start` high in that cycle.
  - WAIT begins after E1.
- The transpose unit registers `done` at E1, so `tp_done` is high in the first WAIT cycle. ACK follows at E2, and `ack` is high between E2 and E3.
- Request-to-ack latency with a nominal transpose unit: 3 cycles. Throughput: one transaction per 4 cycles, because IDLE is mandatory between transactions.
- Watchdog path: request-to-ack = 2 + TIMEOUT cycles, with `err` high in the ACK cycle.
- `busy` is high for exactly the START, WAIT and ACK cycles.
- `grant` is one-hot or zero at all times. `ack` and `err` are never high outside ACK.

## Test plan
- Single request: `req`=0001, `in_mat[0]`=[[1,2,3],[4,5,6],[7,8,9]], with `matrix_transpose` attached.
  - `tp_start` pulses 1 cycle after sample, `ack`=0001 3 cycles after sample, `err`=0.
  - Transposer `Out`=[[1,4,7],[2,5,8],[3,6,9]] during `ack`.
- All four requesters held high from reset release:
  - Grants are in order 0,1,2,3,0.
  - Acks are spaced 4 cycles apart, each with the matching `grant_id`.
- Fairness: `req`=1001 held, `rr_ptr`=0.
  - Grants alternate 0,3,0,3.
  - Requesters 1 and 2 are never granted.
- Stuck unit: `tp_done` tied 0, TIMEOUT=15, `req`=0100.
  - `ack`=0100 and `err`=1 together, 17 cycles after sample.
  - Then IDLE with `busy`=0.
- Input isolation: change `in_mat[1]` to -128 everywhere one cycle after the grant to requester 1 → `tp_in` keeps the captured values.
- Reset mid-WAIT: pull `reset` low during WAIT.
  - All outputs are 0 in the same cycle, with no `ack`.
  - After release with `req`=0010, the next grant goes to requester 1 and `rr_ptr` restarts from 0.
